// File: rtl/age_issue_sched_pkg.sv
// ============================================================================
// Module      : age_issue_sched_pkg
// Description : Shared constants and the entry record for the age-ordered
//               issue scheduler. The defaults here are the parameter
//               defaults used by age_issue_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package age_issue_sched_pkg;

    localparam int c_DEPTH  = 4;
    localparam int c_DATA_W = 32;
    localparam int c_TAG_W  = 6;
    localparam int c_AGE_W  = $clog2(c_DEPTH);

    // One scheduler slot at the default geometry.
    typedef struct packed {
        logic                vld;
        logic                rdy;
        logic [c_AGE_W-1:0]  age;
        logic [c_TAG_W-1:0]  tag;
        logic [c_DATA_W-1:0] data;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/age_oldest_sel.sv
// ============================================================================
// Module      : age_oldest_sel
// Description : Combinational DEPTH-way oldest-first selector. Entry i wins
//               when, against every other candidate j, its age is smaller,
//               or equal with i < j.
// Ports       : cand  - candidate mask
//               age   - per-entry age rank (0 = oldest)
//               grant - one-hot winner
//               idx   - binary index of the winner (0 when none)
//               any   - at least one candidate present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module age_oldest_sel
    import age_issue_sched_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int AGE_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] cand,
    input  logic [AGE_W-1:0] age [DEPTH],
    output logic [DEPTH-1:0] grant,
    output logic [AGE_W-1:0] idx,
    output logic             any
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
            logic w_win;

            always_comb begin
                w_win = cand[gi];
                for (int j = 0; j < DEPTH; j++) begin
                    // Any other candidate that is strictly older, or equally
                    // old at a lower index, knocks this entry out.
                    if (j != gi && cand[j]) begin
                        if ((age[j] < age[gi]) || ((age[j] == age[gi]) && (j < gi))) begin
                            w_win = 1'b0;
                        end
                    end
                end
            end

            assign grant[gi] = w_win;
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                idx = idx | AGE_W'(i);
            end
        end
    end

    assign any = |cand;

endmodule

`default_nettype wire

// File: rtl/age_issue_sched.sv
// ============================================================================
// Module      : age_issue_sched
// Description : Out-of-order issue scheduler. Holds up to DEPTH ops, wakes
//               them on tag broadcast and issues the oldest ready op per
//               cycle. Valid entries always carry the unique ages
//               0..count-1, 0 being the oldest.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               alloc_*               - allocation handshake and payload
//               wake_vld / wake_tag   - tag broadcast
//               out_vld/out_rdy       - issue handshake
//               out_data / out_idx    - selected payload and slot
//               count                 - number of valid entries
//               flush                 - only with AGE_ISSUE_SCHED_FLUSH_EN
// Config      : define AGE_ISSUE_SCHED_FLUSH_EN to add the flush input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module age_issue_sched
    import age_issue_sched_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH,
    parameter int DATA_W = c_DATA_W,
    parameter int TAG_W  = c_TAG_W,
    parameter int AGE_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AGE_ISSUE_SCHED_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_vld,
    output logic              alloc_rdy,
    input  logic [DATA_W-1:0] alloc_data,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic              alloc_ready,
    input  logic              wake_vld,
    input  logic [TAG_W-1:0]  wake_tag,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [AGE_W-1:0]  out_idx,
    output logic [AGE_W:0]    count
);

    localparam logic [AGE_W:0] c_FULL = DEPTH[AGE_W:0];

    typedef struct packed {
        logic              vld;
        logic              rdy;
        logic [AGE_W-1:0]  age;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } sched_entry_t;

    sched_entry_t     r_ent [DEPTH];
    logic [AGE_W:0]   r_count;

    logic             w_flush;
    logic [DEPTH-1:0] w_cand;
    logic [AGE_W-1:0] w_age [DEPTH];
    logic [DEPTH-1:0] w_grant;
    logic [AGE_W-1:0] w_sel_idx;
    logic             w_any;
    logic             w_issue_fire;
    logic             w_alloc_fire;
    logic [AGE_W-1:0] w_free_idx;
    logic [AGE_W-1:0] w_iss_age;
    logic [AGE_W:0]   w_new_age_full;
    logic             w_new_rdy;

`ifdef AGE_ISSUE_SCHED_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
            assign w_cand[gi] = r_ent[gi].vld & r_ent[gi].rdy;
            assign w_age[gi]  = r_ent[gi].age;
        end
    endgenerate

    age_oldest_sel #(
        .DEPTH (DEPTH),
        .AGE_W (AGE_W)
    ) u_sel (
        .cand  (w_cand),
        .age   (w_age),
        .grant (w_grant),
        .idx   (w_sel_idx),
        .any   (w_any)
    );

    // Lowest-index free slot; only meaningful while count < DEPTH.
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_ent[i].vld) begin
                w_free_idx = AGE_W'(i);
            end
        end
    end

    // alloc_rdy looks only at registered count, so a slot freed by this
    // cycle's issue is not offered until the next cycle.
    assign alloc_rdy    = (r_count < c_FULL);
    assign out_vld      = w_any & ~w_flush;
    assign out_data     = r_ent[w_sel_idx].data;
    assign out_idx      = w_sel_idx;
    assign count        = r_count;

    assign w_issue_fire = out_vld & out_rdy;
    assign w_alloc_fire = alloc_vld & alloc_rdy & ~w_flush;
    assign w_iss_age    = r_ent[w_sel_idx].age;

    // A new op is the youngest of the entries that survive this edge.
    assign w_new_age_full = r_count - (AGE_W + 1)'(w_issue_fire);
    assign w_new_rdy      = alloc_ready | (wake_vld & (wake_tag == alloc_tag));

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].vld <= 1'b0;
                r_ent[i].rdy <= 1'b0;
                r_ent[i].age <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue_fire && w_grant[i]) begin
                    r_ent[i].vld <= 1'b0;
                    r_ent[i].rdy <= 1'b0;
                end else if (w_alloc_fire && (w_free_idx == AGE_W'(i))) begin
                    r_ent[i].vld  <= 1'b1;
                    r_ent[i].rdy  <= w_new_rdy;
                    r_ent[i].age  <= w_new_age_full[AGE_W-1:0];
                    r_ent[i].tag  <= alloc_tag;
                    r_ent[i].data <= alloc_data;
                end else if (r_ent[i].vld) begin
                    if (wake_vld && (r_ent[i].tag == wake_tag)) begin
                        r_ent[i].rdy <= 1'b1;
                    end
                    // Close the gap left by the issued entry.
                    if (w_issue_fire && (r_ent[i].age > w_iss_age)) begin
                        r_ent[i].age <= r_ent[i].age - AGE_W'(1);
                    end
                end
            end
            r_count <= r_count + (AGE_W + 1)'(w_alloc_fire) - (AGE_W + 1)'(w_issue_fire);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_age_issue_sched.sv
// ============================================================================
// Module      : tb_age_issue_sched
// Description : Directed, table-driven bench for age_issue_sched (DEPTH=4).
//               Each row drives one cycle of inputs and states the outputs
//               expected just before the rising edge that samples them.
//               Flush coverage is compiled in with AGE_ISSUE_SCHED_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_age_issue_sched;

    localparam int c_DEPTH  = 4;
    localparam int c_DATA_W = 32;
    localparam int c_TAG_W  = 6;
    localparam int c_AGE_W  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                alloc_vld;
    logic                alloc_rdy;
    logic [c_DATA_W-1:0] alloc_data;
    logic [c_TAG_W-1:0]  alloc_tag;
    logic                alloc_ready;
    logic                wake_vld;
    logic [c_TAG_W-1:0]  wake_tag;
    logic                out_vld;
    logic                out_rdy;
    logic [c_DATA_W-1:0] out_data;
    logic [c_AGE_W-1:0]  out_idx;
    logic [c_AGE_W:0]    count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    age_issue_sched #(
        .DEPTH  (c_DEPTH),
        .DATA_W (c_DATA_W),
        .TAG_W  (c_TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef AGE_ISSUE_SCHED_FLUSH_EN
        .flush       (flush),
`endif
        .alloc_vld   (alloc_vld),
        .alloc_rdy   (alloc_rdy),
        .alloc_data  (alloc_data),
        .alloc_tag   (alloc_tag),
        .alloc_ready (alloc_ready),
        .wake_vld    (wake_vld),
        .wake_tag    (wake_tag),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .count       (count)
    );

    typedef struct {
        bit          rst;
        bit          av;
        logic [31:0] ad;
        logic [5:0]  at;
        bit          ar;
        bit          wv;
        logic [5:0]  wt;
        bit          ordy;
        bit          chk;
        bit          e_ardy;
        bit          e_ovld;
        logic [31:0] e_data;
        logic [1:0]  e_idx;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit r, bit av, logic [31:0] ad, logic [5:0] at, bit ar,
                                bit wv, logic [5:0] wt, bit ordy, bit chk, bit e_ardy,
                                bit e_ovld, logic [31:0] e_data, logic [1:0] e_idx,
                                logic [2:0] e_cnt);
        vec_t v;
        v.rst = r;   v.av = av;   v.ad = ad;   v.at = at;   v.ar = ar;
        v.wv = wv;   v.wt = wt;   v.ordy = ordy;
        v.chk = chk; v.e_ardy = e_ardy; v.e_ovld = e_ovld;
        v.e_data = e_data; v.e_idx = e_idx; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; flush = 1'b0; alloc_vld = 1'b0; alloc_data = '0; alloc_tag = '0;
        alloc_ready = 1'b0; wake_vld = 1'b0; wake_tag = '0; out_rdy = 1'b0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;

        //             rst av ad     at ar wv wt ordy chk ardy ovld data   idx cnt
        // reset, then idle
        vq.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0,  0,  0,  0,  32'h0,  0, 0));
        vq.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0,  0,  0,  0,  32'h0,  0, 0));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));
        // in-order ready allocs A, B, C; issue A, B, C
        vq.push_back(mk(0, 1, 32'hA0, 0, 1, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));
        vq.push_back(mk(0, 1, 32'hB0, 0, 1, 0, 0, 0,  1,  1,  1,  32'hA0, 0, 1));
        vq.push_back(mk(0, 1, 32'hC0, 0, 1, 0, 0, 0,  1,  1,  1,  32'hA0, 0, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'hA0, 0, 3));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'hB0, 1, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'hC0, 2, 1));
        // out-of-order wakeup: A2(tag5) B2(tag7) C2(ready) -> issue C2, B2, A2
        vq.push_back(mk(0, 1, 32'h11, 5, 0, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));
        vq.push_back(mk(0, 1, 32'h22, 7, 0, 0, 0, 0,  1,  1,  0,  32'h0,  0, 1));
        vq.push_back(mk(0, 1, 32'h33, 0, 1, 0, 0, 0,  1,  1,  0,  32'h0,  0, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 1, 7, 1,  1,  1,  1,  32'h33, 2, 3));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 1, 5, 1,  1,  1,  1,  32'h22, 1, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'h11, 0, 1));
        // wake bypass into a fresh allocation
        vq.push_back(mk(0, 1, 32'h44, 9, 0, 1, 9, 0,  1,  1,  0,  32'h0,  0, 0));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'h44, 0, 1));
        // age compaction: X(tag1) Y Z ready; issue Y; W lands in Y's slot
        // with age 2, so Z (compacted to 1) must beat W.
        vq.push_back(mk(0, 1, 32'h55, 1, 0, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));
        vq.push_back(mk(0, 1, 32'h66, 0, 1, 0, 0, 0,  1,  1,  0,  32'h0,  0, 1));
        vq.push_back(mk(0, 1, 32'h77, 0, 1, 0, 0, 0,  1,  1,  1,  32'h66, 1, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'h66, 1, 3));
        vq.push_back(mk(0, 1, 32'h88, 0, 1, 0, 0, 0,  1,  1,  1,  32'h77, 2, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 1, 1, 0,  1,  1,  1,  32'h77, 2, 3));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'h55, 0, 3));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'h77, 2, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'h88, 1, 1));
        // fill to DEPTH, then alloc+issue at full and one cycle later
        vq.push_back(mk(0, 1, 32'hE0, 0, 1, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));
        vq.push_back(mk(0, 1, 32'hE1, 0, 1, 0, 0, 0,  1,  1,  1,  32'hE0, 0, 1));
        vq.push_back(mk(0, 1, 32'hE2, 0, 1, 0, 0, 0,  1,  1,  1,  32'hE0, 0, 2));
        vq.push_back(mk(0, 1, 32'hE3, 0, 1, 0, 0, 0,  1,  1,  1,  32'hE0, 0, 3));
        vq.push_back(mk(0, 1, 32'hF0, 0, 1, 0, 0, 1,  1,  0,  1,  32'hE0, 0, 4));
        vq.push_back(mk(0, 1, 32'hF1, 0, 1, 0, 0, 1,  1,  1,  1,  32'hE1, 1, 3));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'hE2, 2, 3));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'hE3, 3, 2));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1,  1,  1,  1,  32'hF1, 0, 1));
        // reset mid-operation drops the pending entry
        vq.push_back(mk(0, 1, 32'h99, 0, 1, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));
        vq.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0,  1,  1,  1,  32'h99, 0, 1));
        vq.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1,  1,  0,  32'h0,  0, 0));

        foreach (vq[k]) begin
            @(negedge clk);
            rst         = vq[k].rst;
            alloc_vld   = vq[k].av;
            alloc_data  = vq[k].ad;
            alloc_tag   = vq[k].at;
            alloc_ready = vq[k].ar;
            wake_vld    = vq[k].wv;
            wake_tag    = vq[k].wt;
            out_rdy     = vq[k].ordy;
            #1;
            if (vq[k].chk) begin
                check("alloc_rdy", k, 32'(alloc_rdy), 32'(vq[k].e_ardy));
                check("out_vld",   k, 32'(out_vld),   32'(vq[k].e_ovld));
                check("count",     k, 32'(count),     32'(vq[k].e_cnt));
                if (vq[k].e_ovld) begin
                    check("out_data", k, out_data,       vq[k].e_data);
                    check("out_idx",  k, 32'(out_idx),   32'(vq[k].e_idx));
                end
            end
        end

        // Same-cycle wake on a different tag must not bypass; the matching
        // wake one cycle later makes the op issuable the cycle after.
        @(negedge clk);
        drive_idle();
        alloc_vld = 1'b1; alloc_data = 32'h5A; alloc_tag = 6'd3; wake_vld = 1'b1; wake_tag = 6'd4;
        @(negedge clk);
        drive_idle();
        wake_vld = 1'b1; wake_tag = 6'd3;
        #1;
        check("no_bypass_vld", 100, 32'(out_vld), 32'd0);
        check("no_bypass_cnt", 100, 32'(count), 32'd1);
        @(negedge clk);
        drive_idle();
        out_rdy = 1'b1;
        #1;
        check("late_wake_vld",  101, 32'(out_vld), 32'd1);
        check("late_wake_data", 101, out_data, 32'h5A);
        @(negedge clk);
        drive_idle();
        #1;
        check("drained_cnt", 102, 32'(count), 32'd0);

`ifdef AGE_ISSUE_SCHED_FLUSH_EN
        // Three pending ops (one ready), then flush with alloc and wake.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            drive_idle();
            alloc_vld = 1'b1; alloc_data = 32'h70 + 32'(n); alloc_tag = 6'd12;
            alloc_ready = (n == 0);
        end
        @(negedge clk);
        drive_idle();
        flush = 1'b1; alloc_vld = 1'b1; alloc_data = 32'h7F; alloc_ready = 1'b1;
        wake_vld = 1'b1; wake_tag = 6'd12; out_rdy = 1'b1;
        #1;
        check("flush_ovld", 200, 32'(out_vld), 32'd0);
        check("flush_pre_cnt", 200, 32'(count), 32'd3);
        @(negedge clk);
        drive_idle();
        #1;
        check("post_flush_cnt",  201, 32'(count), 32'd0);
        check("post_flush_ovld", 201, 32'(out_vld), 32'd0);
        check("post_flush_ardy", 201, 32'(alloc_rdy), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/age_issue_sched.md
Name: age_issue_sched

Overview:
- Small out-of-order issue scheduler. Holds up to DEPTH pending ops, wakes them on tag broadcast, and issues the oldest ready op each cycle.
- Sits between the decode/alloc stage and a shared execution resource.
- Oldest-first selection uses relative age ranks. Smaller age means higher priority; a tie goes to the lower index.

Parameters:
- DEPTH, 4, number of entries (2..16).
- DATA_W, 32, payload width.
- TAG_W, 6, source-tag width used for wakeup.
- AGE_W, $clog2(DEPTH), width of the per-entry age rank.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_vld  in  1  allocation request.
- alloc_rdy  out  1  free entry available; alloc accepted when alloc_vld && alloc_rdy.
- alloc_data  in  DATA_W  payload.
- alloc_tag  in  TAG_W  source tag the op waits on.
- alloc_ready  in  1  op is already ready; the tag is ignored.
- wake_vld  in  1  tag broadcast valid.
- wake_tag  in  TAG_W  broadcast tag.
- out_vld  out  1  at least one valid and ready entry.
- out_rdy  in  1  consumer accepts; issue when out_vld && out_rdy.
- out_data  out  DATA_W  payload of the selected entry.
- out_idx  out  AGE_W  index of the selected entry (debug/verification).
- count  out  AGE_W+1  number of valid entries.

Behaviour:
- Per-entry state: vld, rdy, age[AGE_W-1:0], tag, data.
- Reset (rst=1 at an edge): all vld=0, rdy=0, age=0, count=0. Following from that: alloc_rdy=1, out_vld=0, out_idx=0. out_data is don't-care while out_vld=0.
- Age invariant: the valid entries hold unique ages 0..count-1, with 0 the oldest. There is no wrap-around.
- alloc_rdy = (count < DEPTH). It does not depend on a same-cycle issue, so there is no combinational path from out_rdy.
- Allocation writes the lowest-index free entry:
  - vld=1, tag=alloc_tag, data=alloc_data.
  - age = count - (issue this cycle ? 1 : 0).
  - rdy = alloc_ready || (wake_vld && wake_tag==alloc_tag). A same-cycle wake bypasses into the new entry.
- Wakeup: every valid entry with tag==wake_tag gets rdy=1 next cycle. Already-ready entries are unaffected.
- Selection is combinational from registered state:
  - Candidate = vld && rdy.
  - Pick the candidate with the smallest age; on a tie, the lowest index. Ties cannot occur while the invariant holds.
  - out_vld = any candidate; out_data and out_idx come from the pick.
- Issue: the selected entry has vld=0 and rdy=0 next cycle. Every valid entry with age > the issued age decrements its age by 1.
- Simultaneous alloc + issue: count unchanged; the new entry takes age count-1.
- Full + issue: alloc_rdy stays 0 that cycle; the freed slot is visible next cycle.
- Latency:
  - alloc at cycle t: earliest issue is cycle t+1.
  - wake at t: the woken entry can issue at t+1.
- count = count + alloc_fire - issue_fire.
- out_vld may deassert without handshake only through flush (see Optional Feature). Otherwise a presented op stays until issued or a strictly older op becomes ready.
- rst mid-operation drops all entries; there is no drain.

Optional Feature:
- Macro: AGE_ISSUE_SCHED_FLUSH_EN.
- When defined: adds input flush (1 bit).
  - flush=1 at an edge clears all vld/rdy and sets count=0, identical to rst for entry state.
  - flush has priority over alloc, wake and issue in the same cycle; those events are dropped.
  - out_vld is forced to 0 combinationally while flush=1.
- When undefined: no flush port; entries leave only by issue or rst.

Decomposition:
- Package age_issue_sched_pkg:
  - default DEPTH, DATA_W and TAG_W constants.
  - entry struct typedef {vld, rdy, age, tag, data}, parameterised via localparams.
- Sub-module age_oldest_sel:
  - combinational DEPTH-way selector; inputs cand[DEPTH], age[DEPTH]; outputs onehot grant, index and any.
  - Entry i wins if, for every other candidate j, age_i < age_j, or age_i == age_j and i < j.
  - Reused by other age-ordered arbiters.

Test Plan:
- Reset then idle:
  - stimulus: rst for 2 cycles, then no inputs.
  - response: alloc_rdy=1, out_vld=0, count=0.
- In-order ready allocs:
  - stimulus: alloc A, B, C with alloc_ready=1 on consecutive cycles; out_rdy=1 from cycle 4.
  - response: issue order A, B, C; count goes 3, 2, 1, 0.
- Out-of-order wakeup:
  - stimulus: alloc A(tag 5), B(tag 7), C(ready); wake_tag=7; then wake_tag=5.
  - response: issue order C, B, A. The ages of the remaining entries compact to 0..n-1 after each issue.
- Wake bypass at alloc:
  - stimulus: alloc_tag=9 with alloc_ready=0 and wake_vld=1, wake_tag=9 in the same cycle.
  - response: out_vld=1 next cycle with that entry's data.
- Full boundary with simultaneous alloc and issue:
  - stimulus: fill 4 entries; in the same cycle assert out_rdy and alloc_vld.
  - response: alloc_rdy=0, so the alloc is not taken; next cycle count=3, alloc_rdy=1. An alloc plus issue then keeps count=3 and the new entry has age 2.
- Flush (with AGE_ISSUE_SCHED_FLUSH_EN):
  - stimulus: 3 entries pending; flush=1 together with alloc_vld=1 and wake_vld=1.
  - response: out_vld=0 during flush; count=0 next cycle; the alloc is dropped.
